// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e        : encodings of the 3-bit operation code
//   state_e     : control FSM states
//   op_flags_t  : decoded operation flags kept for the whole operation
//   is_div / is_signed / is_acc / is_sub / decode_op : opcode helpers
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MSUB  = 3'b110,
        OP_MSUBU = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic div;  // divide (otherwise multiply based)
        logic acc;  // accumulate into acc
        logic sub;  // accumulate by subtraction
    } op_flags_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    // Even opcodes are the signed variants.
    function automatic logic is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    function automatic op_flags_t decode_op(input logic [2:0] op);
        op_flags_t f;
        f.div = is_div(op);
        f.acc = is_acc(op);
        f.sub = is_sub(op);
        return f;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle of the multiply/divide unit.
//   start_i/op_i/a_i/b_i/acc_i : request and operands (into the unit)
//   ack_i                      : consumer took the result
//   ready_o/busy_o/valid_o     : unit status
//   result_o/dz_o              : {HI,LO} result and divide-by-zero flag
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic [2:0]           op_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [2*WIDTH-1:0]   acc_i;
    logic                 ack_i;
    logic                 ready_o;
    logic                 busy_o;
    logic                 valid_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 dz_o;

    modport master (
        output start_i, op_i, a_i, b_i, acc_i, ack_i,
        input  ready_o, busy_o, valid_o, result_o, dz_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, acc_i, ack_i,
        output ready_o, busy_o, valid_o, result_o, dz_o
    );
endinterface

// File: rtl/mdu_iter_step.sv
// One radix-2 step of the shared shift/add datapath (combinational).
//   div_i : 1 = restoring divide step, 0 = multiply add-shift step
//   p_i   : working register in; multiply {partial product, multiplier},
//           divide {partial remainder, dividend/quotient}
//   m_i   : multiplicand (multiply) or divisor (divide)
//   p_o   : working register after the step
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0]   m_i,
    output logic [2*WIDTH-1:0] p_o
);
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_top;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    always_comb begin
        // Multiply: add multiplicand on a set LSB, keep the carry, shift right.
        mul_sum  = {1'b0, p_i[2*WIDTH-1:WIDTH]} + {1'b0, (p_i[0] ? m_i : '0)};
        // Divide: remainder shifted left by one takes the next dividend bit.
        // The remainder stays below the divisor, so the W-bit difference
        // is exact whenever the subtraction is taken.
        div_top  = p_i[2*WIDTH-1:WIDTH-1];
        div_ge   = div_top >= {1'b0, m_i};
        div_diff = div_top[WIDTH-1:0] - m_i;
        if (div_i) begin
            p_o = {(div_ge ? div_diff : div_top[WIDTH-1:0]), p_i[WIDTH-2:0], div_ge};
        end else begin
            p_o = {mul_sum, p_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide/multiply-accumulate unit.
//   clk, rst (async, active low), en (0 = stall), annul_i (flush)
//   bus : mdu_iter_if slave port carrying request, operands, ack and
//         the {HI,LO} result with status flags.
// Operands are reduced to magnitudes at start, STEP radix-2 steps run per
// CALC cycle, and FIX applies signs / accumulation before DONE.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      annul_i,
    mdu_iter_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    op_flags_t          op_q, op_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;

    // Step chain: STEP radix-2 steps per CALC cycle.
    logic [2*WIDTH-1:0] chain [STEP+1];
    assign chain[0] = p_q;

    for (genvar g = 0; g < STEP; g++) begin : g_step
        mdu_step #(.WIDTH(WIDTH)) u_step (
            .div_i (op_q.div),
            .p_i   (chain[g]),
            .m_i   (m_q),
            .p_o   (chain[g+1])
        );
    end

    // Operand magnitudes at start; unsigned ops pass through raw.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        a_neg = is_signed(bus.op_i) & bus.a_i[WIDTH-1];
        b_neg = is_signed(bus.op_i) & bus.b_i[WIDTH-1];
        a_mag = a_neg ? -bus.a_i : bus.a_i;
        b_mag = b_neg ? -bus.b_i : bus.b_i;
    end

    // Sign correction and accumulation, written to result_q in FIX.
    logic [2*WIDTH-1:0] prod, fix_res;
    logic [WIDTH-1:0]   quo, rem;
    logic               fix_dz;

    always_comb begin
        prod    = neg_res_q ? -p_q : p_q;
        quo     = neg_res_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        rem     = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
        fix_dz  = op_q.div && (m_q == '0);
        fix_res = prod;
        if (op_q.div) begin
            fix_res = fix_dz ? {a_raw_q, {WIDTH{1'b1}}} : {rem, quo};
        end else if (op_q.acc) begin
            fix_res = op_q.sub ? (acc_q - prod) : (acc_q + prod);
        end
    end

    // NOTE: every next-state value is defaulted to its register first, so
    // no branch below can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        p_d       = p_q;
        m_d       = m_q;
        acc_d     = acc_q;
        a_raw_d   = a_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    op_d      = decode_op(bus.op_i);
                    acc_d     = bus.acc_i;
                    a_raw_d   = bus.a_i;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = 1'b0;
                    cnt_d     = CW'(N);
                    state_d   = CALC;
                    if (is_div(bus.op_i)) begin
                        m_d = b_mag;
                        p_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        m_d = a_mag;
                        p_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end
            end
            CALC: begin
                p_d   = chain[STEP];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                result_d = fix_res;
                dz_d     = fix_dz;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.ack_i) begin
                    dz_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            p_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            a_raw_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
        end else if (annul_i) begin
            // Flush wins over stall and over a same-cycle start; the last
            // written result is kept.
            state_q <= IDLE;
            dz_q    <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            p_q       <= p_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            a_raw_q   <= a_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.ready_o  = (state_q == IDLE);
    assign bus.busy_o   = (state_q == CALC) || (state_q == FIX);
    assign bus.valid_o  = (state_q == DONE);
    assign bus.result_o = result_q;
    assign bus.dz_o     = dz_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: six instances (WIDTH 32/16 x STEP 1/2/4) run in
// lockstep on the same operation and are compared with an arithmetic
// reference model, plus directed cases on the 32-bit STEP=1 instance.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int NDUT = 6;

    logic clk = 1'b0;
    logic rst_n, en, annul, start, ack;
    logic [2:0] op;
    logic [31:0] a_in   [NDUT];
    logic [31:0] b_in   [NDUT];
    logic [63:0] acc_in [NDUT];

    logic [63:0]     res_v [NDUT];
    logic [NDUT-1:0] ready_v, busy_v, valid_v, dz_v;

    logic [63:0] exp_res  [NDUT];
    logic        exp_dz   [NDUT];
    logic [63:0] exp_last [NDUT];
    int          lat      [NDUT];
    logic [63:0] res0;
    logic        dz0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic int w_of(input int g);
        return (g < 3) ? 32 : 16;
    endfunction

    function automatic int n_of(input int g);
        int s;
        s = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
        return w_of(g) / s;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g < 3) ? 32 : 16;
        localparam int S = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
        mdu_iter_if #(.WIDTH(W)) ifc ();
        mdu_iter #(.WIDTH(W), .STEP(S)) u_dut (
            .clk     (clk),
            .rst     (rst_n),
            .en      (en),
            .annul_i (annul),
            .bus     (ifc.slave)
        );
        assign ifc.start_i = start;
        assign ifc.op_i    = op;
        assign ifc.a_i     = a_in[g][W-1:0];
        assign ifc.b_i     = b_in[g][W-1:0];
        assign ifc.acc_i   = acc_in[g][2*W-1:0];
        assign ifc.ack_i   = ack;
        assign res_v[g]    = 64'(ifc.result_o);
        assign ready_v[g]  = ifc.ready_o;
        assign busy_v[g]   = ifc.busy_o;
        assign valid_v[g]  = ifc.valid_o;
        assign dz_v[g]     = ifc.dz_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign-interpreted operands.
    function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] acc, output logic dz);
        logic [31:0] m1;
        logic [63:0] m2, prod, res;
        longint sa, sb, q, r;
        m1 = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        sa = longint'(64'(a & m1));
        sb = longint'(64'(b & m1));
        if (!o[0]) begin
            if (a[w-1]) sa -= longint'(1) << w;
            if (b[w-1]) sb -= longint'(1) << w;
        end
        dz   = 1'b0;
        prod = 64'(sa * sb);
        case (o)
            3'b010, 3'b011: begin
                if (sb == 0) begin
                    dz  = 1'b1;
                    res = (64'(a & m1) << w) | 64'(m1);
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = ((64'(r) & 64'(m1)) << w) | (64'(q) & 64'(m1));
                end
            end
            3'b100, 3'b101: res = acc + prod;
            3'b110, 3'b111: res = acc - prod;
            default:        res = prod;
        endcase
        return res & m2;
    endfunction

    // Cycles to valid: N+2, plus each stalled cycle before valid appears.
    function automatic int exp_lat(input int n, input int st_at, input int st_len);
        int e;
        e = n + 2;
        for (int k = 1; k < e; k++)
            if (st_len > 0 && k >= st_at && k < st_at + st_len) e++;
        return e;
    endfunction

    function automatic logic [31:0] rnd_val(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return m;
            3:       return 32'h1 << (w - 1);
            4:       return m >> 1;
            default: return $urandom & m;
        endcase
    endfunction

    task automatic load_op(input logic [2:0] o, input logic [31:0] a32, input logic [31:0] b32,
                           input logic [63:0] acc64, input logic [31:0] a16,
                           input logic [31:0] b16, input logic [31:0] acc32);
        logic d;
        for (int g = 0; g < NDUT; g++) begin
            if (w_of(g) == 32) begin
                a_in[g] = a32; b_in[g] = b32; acc_in[g] = acc64;
            end else begin
                a_in[g] = a16 & 32'hFFFF; b_in[g] = b16 & 32'hFFFF; acc_in[g] = {32'h0, acc32};
            end
            exp_res[g] = model(w_of(g), o, a_in[g], b_in[g], acc_in[g], d);
            exp_dz[g]  = d;
            lat[g]     = -1;
        end
        op = o;
    endtask

    // Advance from cycle 1 to cycle `upto` (sampling #1 after each edge).
    task automatic step_to(input int upto, output logic saw_valid0);
        saw_valid0 = 1'b0;
        for (int k = 1; k < upto; k++) begin
            saw_valid0 |= valid_v[0];
            @(posedge clk); #1;
        end
        saw_valid0 |= valid_v[0];
    endtask

    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a32, input logic [31:0] b32, input logic [63:0] acc64,
                          input logic [31:0] a16, input logic [31:0] b16, input logic [31:0] acc32,
                          input int st_at, input int st_len);
        int k;
        load_op(o, a32, b32, acc64, a16, b16, acc32);
        start = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 1; k <= 200; k++) begin
            en = !(st_len > 0 && k >= st_at && k < st_at + st_len);
            for (int g = 0; g < NDUT; g++)
                if (valid_v[g] && lat[g] < 0) lat[g] = k;
            if (valid_v == '1) break;
            @(posedge clk); #1;
        end
        en = 1'b1;
        check({tag, " all_valid"}, 64'(valid_v), 64'h3F);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s[%0d] result", tag, g), res_v[g], exp_res[g]);
            check($sformatf("%s[%0d] dz", tag, g), 64'(dz_v[g]), 64'(exp_dz[g]));
            check($sformatf("%s[%0d] latency", tag, g), 64'(lat[g]),
                  64'(exp_lat(n_of(g), st_at, st_len)));
            exp_last[g] = exp_res[g];
        end
        res0 = res_v[0];
        dz0  = dz_v[0];
        // A start while results wait for ack must be ignored.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_hold valid"}, 64'(valid_v), 64'h3F);
        check({tag, " done_hold result"}, res_v[0], exp_res[0]);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check({tag, " ack ready"}, 64'(ready_v), 64'h3F);
        check({tag, " ack valid"}, 64'(valid_v), 64'h0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ready"}, 64'(ready_v), 64'h3F);
        check({tag, " busy"}, 64'(busy_v), 64'h0);
        check({tag, " valid"}, 64'(valid_v), 64'h0);
        check({tag, " dz"}, 64'(dz_v), 64'h0);
        for (int g = 0; g < NDUT; g++)
            check($sformatf("%s[%0d] result", tag, g), res_v[g], exp_last[g]);
    endtask

    initial begin
        logic seen;
        logic [2:0]  o;
        logic [31:0] a32, b32, a16, b16, acc32;
        logic [63:0] acc64;
        int st_at, st_len;

        rst_n = 1'b0; en = 1'b1; annul = 1'b0; start = 1'b0; ack = 1'b0; op = 3'b0;
        for (int g = 0; g < NDUT; g++) begin
            a_in[g] = '0; b_in[g] = '0; acc_in[g] = '0; exp_last[g] = '0;
        end
        #12;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'h0, 32'hFFFD, 32'd7, 32'h0, 0, 0);
        check("mult literal", res0, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mult lat34", 64'(lat[0]), 64'd34);
        check("mult dz", 64'(dz0), 64'h0);

        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'h0, 32'hFFF9, 32'd2, 32'h0, 0, 0);
        check("div literal", res0, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("divu0", OP_DIVU, 32'd7, 32'd0, 64'h0, 32'd7, 32'd0, 32'h0, 0, 0);
        check("divu0 literal", res0, 64'h0000_0007_FFFF_FFFF);
        check("divu0 dz", 64'(dz0), 64'h1);

        run_op("msubu", OP_MSUBU, 32'd3, 32'd4, 64'h10, 32'd3, 32'd4, 32'h10, 0, 0);
        check("msubu literal", res0, 64'h4);

        run_op("madd", OP_MADD, 32'h8000_0000, 32'h8000_0000, 64'h0,
               32'h8000, 32'h8000, 32'h0, 0, 0);
        check("madd literal", res0, 64'h4000_0000_0000_0000);

        run_op("divmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0,
               32'h8000, 32'hFFFF, 32'h0, 0, 0);
        check("divmin literal", res0, 64'h0000_0000_8000_0000);
        check("divmin dz", 64'(dz0), 64'h0);

        run_op("stall", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'h0, 32'hFFFD, 32'd7, 32'h0, 10, 5);
        check("stall lat39", 64'(lat[0]), 64'd39);
        check("stall literal", res0, 64'hFFFF_FFFF_FFFF_FFEB);

        // Annul in CALC cycle 10: faster instances already finished by then.
        load_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 32'h5678, 32'hDEF0, 32'h0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        step_to(10, seen);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul valid0 seen", 64'(seen), 64'h0);
        for (int g = 0; g < NDUT; g++)
            if (n_of(g) + 2 <= 10) exp_last[g] = exp_res[g];
        check_idle("annul");

        run_op("after_annul", OP_DIVU, 32'd100, 32'd7, 64'h0, 32'd100, 32'd7, 32'h0, 0, 0);

        // Annul beats a same-cycle start.
        load_op(OP_MULT, 32'd5, 32'd5, 64'h0, 32'd5, 32'd5, 32'h0);
        start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        check_idle("annul_start");

        // Reset pulse mid-CALC.
        load_op(OP_DIV, 32'hDEAD_BEEF, 32'd13, 64'h0, 32'hBEEF, 32'd13, 32'h0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        step_to(10, seen);
        rst_n = 1'b0;
        #2;
        for (int g = 0; g < NDUT; g++) exp_last[g] = '0;
        check_idle("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            o      = 3'($urandom_range(0, 7));
            a32    = rnd_val(32);
            b32    = rnd_val(32);
            a16    = rnd_val(16);
            b16    = rnd_val(16);
            acc64  = {$urandom, $urandom};
            acc32  = $urandom;
            st_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            st_at  = int'($urandom_range(2, 5));
            run_op($sformatf("rnd%0d", i), o, a32, b32, acc64, a16, b16, acc32, st_at, st_len);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
